bw_io_ddr_pvt_cal_ctl: RTL and testbench
========================================

Name: bw_io_ddr_pvt_cal_ctl

Overview:
- Calibration sequencer that computes the DDR pad pull-up (cbu) and pull-down (cbd) impedance codes from replica-leg comparator results.
- Pushes the codes into the pad-side PVT enable/latch stage with a one-cycle enable pulse, only inside a DRAM-idle update window.
- Runs a full calibration on request, then optional periodic single-step tracking updates.

Parameters:
- CODE_W, 8, width of each impedance code.
- INIT_CODE, 8'h80, reset and start value of both codes.
- SETTLE_CYC, 16, cycles the replica leg settles after leg select before the comparator is sampled (minimum 1).
- PERIOD, 4096, idle cycles between periodic tracking updates.
- MAX_ITER, 64, iteration limit of a full calibration.

Ports:
- clk  in  1  block clock
- arst_l  in  1  asynchronous active-low reset
- cal_start  in  1  one-cycle pulse; request full calibration
- per_en  in  1  enable periodic tracking
- cmp_up  in  1  synchronized pull-up replica comparator; 1 = leg too weak
- cmp_dn  in  1  synchronized pull-down replica comparator; 1 = leg too weak
- upd_ok  in  1  DRAM idle; pad codes may change
- sel_up  out  1  connect pull-up replica to comparator
- sel_dn  out  1  connect pull-down replica to comparator
- cbu_code  out  CODE_W  pull-up code to the pad enable stage
- cbd_code  out  CODE_W  pull-down code to the pad enable stage
- pvt_en  out  1  one-cycle load enable to the pad enable stage
- cal_busy  out  1  sequence in progress
- cal_done  out  1  one-cycle pulse, coincident with pvt_en
- cal_locked  out  1  last full calibration converged

Behaviour:
- Reset values: cbu_code = cbd_code = INIT_CODE; working codes = INIT_CODE; all 1-bit outputs 0; timer = 0; FSM = IDLE.
- Reset asserted mid-operation aborts the sequence immediately; no pvt_en is issued.
- FSM states: IDLE, SET_UP, SMP_UP, SET_DN, SMP_DN, CHK, WAIT_UPD, LOAD, PUSH.
- IDLE:
  - The timer counts only while per_en=1; it clears when per_en=0.
  - cal_start starts a full calibration: mode=FULL, iteration count=0, reversal flags cleared.
  - Timer reaching PERIOD-1 starts a tracking pass: mode=TRACK.
  - If cal_start and timer expiry occur in the same cycle, FULL wins.
  - cal_start is ignored whenever the FSM is not in IDLE.
- SET_UP: sel_up=1 for SETTLE_CYC cycles, then SMP_UP.
- SMP_UP (1 cycle, sel_up still 1): working cbu steps +1 if cmp_up=1, else -1.
  - Saturates at 0 and 2^CODE_W-1.
  - A reversal is recorded when the step direction differs from the previous cbu direction.
  - The direction register is updated.
- SET_DN / SMP_DN: identical for the cbd leg, using sel_dn and cmp_dn.
- sel_up and sel_dn are never high in the same cycle. There is one idle cycle (sel both 0) between SMP_UP and SET_DN.
- CHK (1 cycle), iteration count +1:
  - TRACK: go to WAIT_UPD.
  - FULL, both legs have seen a reversal: cal_locked=1, go to WAIT_UPD.
  - FULL, iteration count = MAX_ITER: cal_locked=0, go to WAIT_UPD.
  - Otherwise: SET_UP.
  - A leg that is saturating keeps stepping in the same direction, so it never records a reversal and the calibration ends unlocked at MAX_ITER.
- WAIT_UPD: waits indefinitely for upd_ok=1; cal_busy stays 1.
- LOAD (1 cycle): cbu_code and cbd_code are loaded from the working codes. Outputs are stable one full cycle before pvt_en.
- PUSH (1 cycle): pvt_en=1 and cal_done=1. Next state IDLE; the timer clears.
- If upd_ok drops during LOAD or PUSH, the sequence still completes. The upstream window guarantees at least 2 cycles.
- cal_busy = (FSM != IDLE).
- cal_locked changes only at CHK of a FULL pass. TRACK passes leave it unchanged.
- Latency of a TRACK pass with upd_ok=1: 2*SETTLE_CYC + 7 cycles from timer expiry to pvt_en.

Optional Feature:
- Macro: BW_IO_DDR_PVT_CAL_HYST_EN.
- Defined: in TRACK mode a code steps only after two consecutive samples in the same direction, using a per-leg pending-direction bit.
  - A pass whose sample disagrees with the pending bit produces no step and replaces the pending bit.
  - FULL mode is unaffected.
- Undefined: every sample steps. The pending registers do not exist.

Decomposition:
- Shared package bw_io_ddr_pvt_pkg holds:
  - the FSM state enum;
  - the mode enum (FULL/TRACK);
  - CODE_W;
  - INIT_CODE;
  - the saturating step function.
- Sub-module bw_io_ddr_pvt_leg is instantiated twice (up/dn). It contains:
  - the working code register;
  - the saturating up/down step;
  - the direction and reversal flags;
  - the hysteresis pending bit when the macro is defined.
- The top holds the FSM, settle counter, period timer and output registers.

Test Plan:
1. Reset with cmp both 1 → cbu_code=cbd_code=8'h80, pvt_en=0, cal_busy=0; holds until cal_start.
2. cal_start; cmp_up=1 until cbu reaches 8'h84 then toggles; cmp_dn=0 until cbd reaches 8'h7D then toggles; upd_ok=1 → single pvt_en pulse, cal_locked=1, codes within ±1 of 8'h84 / 8'h7D, and the codes are stable in the cycle before pvt_en.
3. FULL calibration with cmp_up stuck 1 and MAX_ITER=64 → cbu_code=8'hC0, cal_locked=0, one pvt_en pulse.
4. Saturation: INIT_CODE=8'hFE with cmp_up=1 → cbu never exceeds 8'hFF and never wraps to 8'h00.
5. upd_ok=0 for 500 cycles after CHK → no pvt_en and cal_busy=1 throughout; upd_ok rising gives pvt_en exactly 2 cycles later.
6. Tracking: per_en=1, PERIOD=32, SETTLE_CYC=4, cmp_up=1 → pvt_en every 47 cycles, cbu +1 per pass (+1 every second pass with BW_IO_DDR_PVT_CAL_HYST_EN defined); arst_l pulsed mid-SET_DN → outputs return to reset values and no pvt_en occurs.

Source files
------------

// File: rtl/bw_io_ddr_pvt_pkg.sv
// Shared types and helpers for the DDR pad PVT calibration controller.
// Feature macro BW_IO_DDR_PVT_CAL_HYST_EN is consumed by bw_io_ddr_pvt_leg.
package bw_io_ddr_pvt_pkg;

  localparam int PVT_CODE_W = 8;
  localparam logic [PVT_CODE_W-1:0] PVT_INIT_CODE = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_UP,
    ST_SMP_UP,
    ST_SET_DN,
    ST_SMP_DN,
    ST_CHK,
    ST_WAIT_UPD,
    ST_LOAD,
    ST_PUSH
  } state_t;

  typedef enum logic {
    MODE_FULL,
    MODE_TRACK
  } mode_t;

  // One code step towards the comparator's request, clamped to [0, max_code].
  function automatic logic [31:0] sat_step(input logic [31:0] code,
                                           input logic [31:0] max_code,
                                           input logic up);
    if (up) begin
      return (code >= max_code) ? code : code + 32'd1;
    end
    return (code == 32'd0) ? code : code - 32'd1;
  endfunction

endpackage

// File: rtl/bw_io_ddr_pvt_leg.sv
// One replica leg: working impedance code, saturating step, direction/reversal tracking.
// With BW_IO_DDR_PVT_CAL_HYST_EN defined, tracking steps need two agreeing samples.
module bw_io_ddr_pvt_leg
  import bw_io_ddr_pvt_pkg::*;
#(
  parameter int W = PVT_CODE_W,
  parameter logic [W-1:0] INIT = W'(PVT_INIT_CODE)
) (
  input  logic         clk,
  input  logic         arst_l,
  input  logic         clr,
  input  logic         smp,
  input  logic         cmp,
`ifdef BW_IO_DDR_PVT_CAL_HYST_EN
  input  logic         track,
`endif
  output logic [W-1:0] code,
  output logic         rev
);

  localparam logic [31:0] MAX_CODE = 32'((64'd1 << W) - 64'd1);

  logic dir;
  logic dir_vld;
  logic do_step;

`ifdef BW_IO_DDR_PVT_CAL_HYST_EN
  logic pend_vld;
  logic pend_dir;

  assign do_step = !track || (pend_vld && (pend_dir == cmp));

  // A disagreeing (or first) tracking sample only arms the pending direction.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      pend_vld <= 1'b0;
      pend_dir <= 1'b0;
    end else if (smp && track) begin
      if (do_step) begin
        pend_vld <= 1'b0;
      end else begin
        pend_vld <= 1'b1;
        pend_dir <= cmp;
      end
    end
  end
`else
  assign do_step = 1'b1;
`endif

  // dir_vld keeps the first step of a full calibration from counting as a reversal.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      code    <= INIT;
      dir     <= 1'b0;
      dir_vld <= 1'b0;
      rev     <= 1'b0;
    end else if (clr) begin
      dir_vld <= 1'b0;
      rev     <= 1'b0;
    end else if (smp && do_step) begin
      code    <= W'(sat_step(32'(code), MAX_CODE, cmp));
      dir     <= cmp;
      dir_vld <= 1'b1;
      if (dir_vld && (dir != cmp)) begin
        rev <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bw_io_ddr_pvt_cal_ctl.sv
// DDR pad PVT calibration sequencer: full calibration on request, periodic tracking,
// code push inside the DRAM-idle window. Optional macro: BW_IO_DDR_PVT_CAL_HYST_EN.
module bw_io_ddr_pvt_cal_ctl
  import bw_io_ddr_pvt_pkg::*;
#(
  parameter int CODE_W = PVT_CODE_W,
  parameter logic [CODE_W-1:0] INIT_CODE = CODE_W'(PVT_INIT_CODE),
  parameter int SETTLE_CYC = 16,
  parameter int PERIOD = 4096,
  parameter int MAX_ITER = 64
) (
  input  logic              clk,
  input  logic              arst_l,
  input  logic              cal_start,
  input  logic              per_en,
  input  logic              cmp_up,
  input  logic              cmp_dn,
  input  logic              upd_ok,
  output logic              sel_up,
  output logic              sel_dn,
  output logic [CODE_W-1:0] cbu_code,
  output logic [CODE_W-1:0] cbd_code,
  output logic              pvt_en,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_locked
);

  localparam logic [31:0] TMR_LAST   = 32'(PERIOD - 1);
  localparam logic [31:0] UP_LAST    = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] DN_LAST    = 32'(SETTLE_CYC);
  localparam logic [31:0] ITER_LIMIT = 32'(MAX_ITER);

  state_t      state;
  mode_t       mode;
  logic [31:0] timer;
  logic [31:0] settle;
  logic [31:0] iter;

  logic              leg_clr;
  logic [CODE_W-1:0] work_up;
  logic [CODE_W-1:0] work_dn;
  logic              rev_up;
  logic              rev_dn;

  assign leg_clr = (state == ST_IDLE) && cal_start;

  bw_io_ddr_pvt_leg #(.W(CODE_W), .INIT(INIT_CODE)) u_leg_up (
    .clk    (clk),
    .arst_l (arst_l),
    .clr    (leg_clr),
    .smp    (state == ST_SMP_UP),
    .cmp    (cmp_up),
`ifdef BW_IO_DDR_PVT_CAL_HYST_EN
    .track  (mode == MODE_TRACK),
`endif
    .code   (work_up),
    .rev    (rev_up)
  );

  bw_io_ddr_pvt_leg #(.W(CODE_W), .INIT(INIT_CODE)) u_leg_dn (
    .clk    (clk),
    .arst_l (arst_l),
    .clr    (leg_clr),
    .smp    (state == ST_SMP_DN),
    .cmp    (cmp_dn),
`ifdef BW_IO_DDR_PVT_CAL_HYST_EN
    .track  (mode == MODE_TRACK),
`endif
    .code   (work_dn),
    .rev    (rev_dn)
  );

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state      <= ST_IDLE;
      mode       <= MODE_FULL;
      timer      <= '0;
      settle     <= '0;
      iter       <= '0;
      sel_up     <= 1'b0;
      sel_dn     <= 1'b0;
      cbu_code   <= INIT_CODE;
      cbd_code   <= INIT_CODE;
      pvt_en     <= 1'b0;
      cal_done   <= 1'b0;
      cal_busy   <= 1'b0;
      cal_locked <= 1'b0;
    end else begin
      pvt_en   <= 1'b0;
      cal_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cal_start) begin
            mode     <= MODE_FULL;
            iter     <= '0;
            timer    <= '0;
            settle   <= '0;
            sel_up   <= 1'b1;
            cal_busy <= 1'b1;
            state    <= ST_SET_UP;
          end else if (per_en && (timer == TMR_LAST)) begin
            mode     <= MODE_TRACK;
            timer    <= '0;
            settle   <= '0;
            sel_up   <= 1'b1;
            cal_busy <= 1'b1;
            state    <= ST_SET_UP;
          end else if (per_en) begin
            timer <= timer + 32'd1;
          end else begin
            timer <= '0;
          end
        end
        ST_SET_UP: begin
          if (settle == UP_LAST) begin
            state <= ST_SMP_UP;
          end else begin
            settle <= settle + 32'd1;
          end
        end
        ST_SMP_UP: begin
          sel_up <= 1'b0;
          settle <= '0;
          state  <= ST_SET_DN;
        end
        // First SET_DN cycle keeps both selects low so the legs never overlap.
        ST_SET_DN: begin
          sel_dn <= 1'b1;
          if (settle == DN_LAST) begin
            state <= ST_SMP_DN;
          end else begin
            settle <= settle + 32'd1;
          end
        end
        ST_SMP_DN: begin
          sel_dn <= 1'b0;
          state  <= ST_CHK;
        end
        ST_CHK: begin
          iter <= iter + 32'd1;
          if (mode == MODE_TRACK) begin
            state <= ST_WAIT_UPD;
          end else if (rev_up && rev_dn) begin
            cal_locked <= 1'b1;
            state      <= ST_WAIT_UPD;
          end else if ((iter + 32'd1) == ITER_LIMIT) begin
            cal_locked <= 1'b0;
            state      <= ST_WAIT_UPD;
          end else begin
            settle <= '0;
            sel_up <= 1'b1;
            state  <= ST_SET_UP;
          end
        end
        // Codes change on entry to LOAD so they are stable a full cycle before pvt_en.
        ST_WAIT_UPD: begin
          if (upd_ok) begin
            cbu_code <= work_up;
            cbd_code <= work_dn;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          pvt_en   <= 1'b1;
          cal_done <= 1'b1;
          state    <= ST_PUSH;
        end
        ST_PUSH: begin
          timer    <= '0;
          cal_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bw_io_ddr_pvt_cal_ctl.sv
// Directed scoreboard bench for bw_io_ddr_pvt_cal_ctl (honours BW_IO_DDR_PVT_CAL_HYST_EN).
module tb_bw_io_ddr_pvt_cal_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_l, cal_start, per_en, cmp_up, cmp_dn, upd_ok;
  logic       sel_up, sel_dn, pvt_en, cal_busy, cal_done, cal_locked;
  logic [7:0] cbu_code, cbd_code;

  logic       s_start, s_upd_ok, s_cmp_up, s_cmp_dn;
  logic       s_sel_up, s_sel_dn, s_pvt_en, s_busy, s_done, s_locked;
  logic [7:0] s_cbu, s_cbd;

  bw_io_ddr_pvt_cal_ctl #(.CODE_W(8), .INIT_CODE(8'h80), .SETTLE_CYC(4), .PERIOD(32),
                          .MAX_ITER(64)) u_dut (
    .clk(clk), .arst_l(arst_l), .cal_start(cal_start), .per_en(per_en),
    .cmp_up(cmp_up), .cmp_dn(cmp_dn), .upd_ok(upd_ok), .sel_up(sel_up), .sel_dn(sel_dn),
    .cbu_code(cbu_code), .cbd_code(cbd_code), .pvt_en(pvt_en), .cal_busy(cal_busy),
    .cal_done(cal_done), .cal_locked(cal_locked)
  );

  bw_io_ddr_pvt_cal_ctl #(.CODE_W(8), .INIT_CODE(8'hFE), .SETTLE_CYC(1), .PERIOD(4096),
                          .MAX_ITER(4)) u_sat (
    .clk(clk), .arst_l(arst_l), .cal_start(s_start), .per_en(1'b0),
    .cmp_up(s_cmp_up), .cmp_dn(s_cmp_dn), .upd_ok(s_upd_ok), .sel_up(s_sel_up),
    .sel_dn(s_sel_dn), .cbu_code(s_cbu), .cbd_code(s_cbd), .pvt_en(s_pvt_en),
    .cal_busy(s_busy), .cal_done(s_done), .cal_locked(s_locked)
  );

  typedef struct {
    logic [7:0] cbu;
    logic [7:0] cbd;
    logic       locked;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   cyc = 0;
  int   last_pulse = -1;
  bit   gap_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] step8(input logic [7:0] c, input logic up);
    if (up) return (c == 8'hFF) ? c : c + 8'd1;
    return (c == 8'h00) ? c : c - 8'd1;
  endfunction

  // Monitor: pops the scoreboard on each pvt_en pulse of the main instance.
  initial begin
    logic [7:0] prev_cbu, prev_cbd;
    exp_t e;
    prev_cbu = 8'h80;
    prev_cbd = 8'h80;
    forever begin
      @(negedge clk);
      cyc++;
      if (sel_up && sel_dn) check("sel_exclusive", {30'd0, sel_up, sel_dn}, 32'd2);
      if (pvt_en) begin
        pulses++;
        check("cal_done_with_pvt_en", {31'd0, cal_done}, 32'd1);
        check("codes_stable_before_pvt_en", {16'd0, prev_cbu, prev_cbd},
              {16'd0, cbu_code, cbd_code});
        if (gap_chk && last_pulse >= 0) check("track_period", cyc - last_pulse, 32'd47);
        last_pulse = cyc;
        if (sb.size() == 0) begin
          check("pvt_en_expected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          $display("pvt_en: cbu=%02h cbd=%02h locked=%0b (exp %02h %02h %0b)",
                   cbu_code, cbd_code, cal_locked, e.cbu, e.cbd, e.locked);
          check("sb_cbu", {24'd0, cbu_code}, {24'd0, e.cbu});
          check("sb_cbd", {24'd0, cbd_code}, {24'd0, e.cbd});
          check("sb_locked", {31'd0, cal_locked}, {31'd0, e.locked});
        end
      end
      prev_cbu = cbu_code;
      prev_cbd = cbd_code;
    end
  end

  initial begin
    logic [7:0] mdl_up, mdl_dn;
    logic       psu, psd;
    int         p0, n_pulse, n_idle, n_wrap;

    arst_l = 1'b0; cal_start = 1'b0; per_en = 1'b0; cmp_up = 1'b1; cmp_dn = 1'b1; upd_ok = 1'b0;
    s_start = 1'b0; s_upd_ok = 1'b1; s_cmp_up = 1'b1; s_cmp_dn = 1'b0;
    repeat (3) @(negedge clk);
    arst_l = 1'b1;

    // 1: reset state holds while nothing is requested
    repeat (20) @(negedge clk);
    check("rst_cbu", {24'd0, cbu_code}, 32'h80);
    check("rst_cbd", {24'd0, cbd_code}, 32'h80);
    check("rst_pvt_en", {31'd0, pvt_en}, 32'd0);
    check("rst_busy", {31'd0, cal_busy}, 32'd0);
    check("rst_locked", {31'd0, cal_locked}, 32'd0);
    check("rst_sel", {30'd0, sel_up, sel_dn}, 32'd0);
    check("rst_no_pulse", pulses, 32'd0);

    // 2: converging full calibration
    mdl_up = 8'h80; mdl_dn = 8'h80; psu = 1'b0; psd = 1'b0;
    upd_ok = 1'b1;
    cmp_up = (mdl_up < 8'h84);
    cmp_dn = (mdl_dn <= 8'h7D);
    sb.push_back('{8'h83, 8'h7D, 1'b1});
    p0 = pulses;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    check("t2_busy", {31'd0, cal_busy}, 32'd1);
    for (int c = 0; c < 2000 && pulses == p0; c++) begin
      @(negedge clk);
      if (psu && !sel_up) mdl_up = step8(mdl_up, cmp_up);
      if (psd && !sel_dn) mdl_dn = step8(mdl_dn, cmp_dn);
      psu = sel_up;
      psd = sel_dn;
      cmp_up = (mdl_up < 8'h84);
      cmp_dn = (mdl_dn <= 8'h7D);
    end
    repeat (5) @(negedge clk);
    check("t2_pulse_count", pulses - p0, 32'd1);
    check("t2_idle_after", {31'd0, cal_busy}, 32'd0);

    arst_l = 1'b0;
    @(negedge clk);
    arst_l = 1'b1;
    check("rst_clears_locked", {31'd0, cal_locked}, 32'd0);

    // 3 + 5: stuck comparator runs to MAX_ITER, then waits for the update window
    cmp_up = 1'b1; cmp_dn = 1'b1; upd_ok = 1'b0;
    sb.push_back('{8'hC0, 8'hC0, 1'b0});
    p0 = pulses;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    n_pulse = 0; n_idle = 0;
    repeat (1500) begin
      @(negedge clk);
      if (pvt_en) n_pulse++;
      if (!cal_busy) n_idle++;
    end
    check("t5_no_pvt_en_blocked", n_pulse, 32'd0);
    check("t5_busy_while_blocked", n_idle, 32'd0);
    upd_ok = 1'b1;
    @(negedge clk);
    check("t5_pvt_en_plus1", {31'd0, pvt_en}, 32'd0);
    check("t3_code_early", {24'd0, cbu_code}, 32'hC0);
    @(negedge clk);
    check("t5_pvt_en_plus2", {31'd0, pvt_en}, 32'd1);
    @(negedge clk);
    check("t5_pvt_en_drop", {31'd0, pvt_en}, 32'd0);
    check("t3_pulse_count", pulses - p0, 32'd1);

    // 4: saturation at the top of the code range
    n_wrap = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 0; c < 500 && !s_pvt_en; c++) begin
      @(negedge clk);
      if (s_cbu == 8'h00) n_wrap++;
    end
    $display("sat pvt_en: cbu=%02h cbd=%02h locked=%0b", s_cbu, s_cbd, s_locked);
    check("t4_pvt_en", {31'd0, s_pvt_en}, 32'd1);
    check("t4_cbu_sat", {24'd0, s_cbu}, 32'hFF);
    check("t4_cbd", {24'd0, s_cbd}, 32'hFA);
    check("t4_unlocked", {31'd0, s_locked}, 32'd0);
    check("t4_no_wrap", n_wrap, 32'd0);

    // 6: periodic tracking, then reset in the middle of SET_DN
    arst_l = 1'b0;
    @(negedge clk);
    arst_l = 1'b1;
    cmp_up = 1'b1; cmp_dn = 1'b0; upd_ok = 1'b1;
`ifdef BW_IO_DDR_PVT_CAL_HYST_EN
    sb.push_back('{8'h80, 8'h80, 1'b0});
    sb.push_back('{8'h81, 8'h7F, 1'b0});
    sb.push_back('{8'h81, 8'h7F, 1'b0});
    sb.push_back('{8'h82, 8'h7E, 1'b0});
`else
    sb.push_back('{8'h81, 8'h7F, 1'b0});
    sb.push_back('{8'h82, 8'h7E, 1'b0});
    sb.push_back('{8'h83, 8'h7D, 1'b0});
    sb.push_back('{8'h84, 8'h7C, 1'b0});
`endif
    last_pulse = -1;
    gap_chk = 1'b1;
    p0 = pulses;
    per_en = 1'b1;
    for (int c = 0; c < 300 && (pulses - p0) < 4; c++) @(negedge clk);
    check("t6_track_pulses", pulses - p0, 32'd4);
    gap_chk = 1'b0;
    for (int c = 0; c < 200 && !sel_dn; c++) @(negedge clk);
    check("t6_reach_set_dn", {31'd0, sel_dn}, 32'd1);
    arst_l = 1'b0;
    #1;
    check("t6_rst_cbu", {24'd0, cbu_code}, 32'h80);
    check("t6_rst_cbd", {24'd0, cbd_code}, 32'h80);
    check("t6_rst_busy", {31'd0, cal_busy}, 32'd0);
    check("t6_rst_sel", {30'd0, sel_up, sel_dn}, 32'd0);
    check("t6_rst_pvt_en", {31'd0, pvt_en}, 32'd0);
    @(negedge clk);
    arst_l = 1'b1;
    per_en = 1'b0;
    p0 = pulses;
    repeat (200) @(negedge clk);
    check("t6_no_pvt_en_after_rst", pulses - p0, 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
